// File: rtl/gf2m_lsb_serial_mult.sv
// Bit-serial GF(2^M) multiplier, polynomial basis, multiplier consumed LSB-first.
// One partial-product step per cycle; the result is held until the downstream handshake.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CALC  | M shift-and-reduce steps, busy high
//   DONE  | product on c, out_valid high until out_ready
module gf2m_lsb_serial_mult #(
    parameter int              M    = 16,
    parameter logic [M-1:0]    POLY = 16'h100B
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c,
    output logic         busy
);

    localparam int              CW   = $clog2(M) + 1;
    localparam logic [CW-1:0]   LAST = CW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [M-1:0]   a_reg, b_reg, c_acc, acc_nxt, a_shift;
    logic [CW-1:0]  cnt;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);

    // Multiply a_reg by x and reduce modulo g(x).
    assign a_shift = {a_reg[M-2:0], 1'b0} ^ (a_reg[M-1] ? POLY : '0);
    assign acc_nxt = b_reg[0] ? (c_acc ^ a_reg) : c_acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            c_acc <= '0;
            cnt   <= '0;
            c     <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        c_acc <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    c_acc <= acc_nxt;
                    a_reg <= a_shift;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) c <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_lsb_serial_mult.sv
// Directed and randomized checks for the serial GF(2^16) multiplier.
module tb_gf2m_lsb_serial_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] c;
    logic        busy;

    int checks = 0;
    int errors = 0;

    gf2m_lsb_serial_mult #(.M(16), .POLY(16'h100B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Schoolbook product followed by top-down reduction by x^16+x^12+x^3+x+1.
    function automatic logic [15:0] gf_mul(input logic [15:0] x, input logic [15:0] y);
        logic [30:0] p;
        logic [30:0] g;
        p = '0;
        g = 31'h1100B;
        for (int i = 0; i < 16; i++)
            if (y[i]) p = p ^ (31'(x) << i);
        for (int i = 30; i >= 16; i--)
            if (p[i]) p = p ^ (g << (i - 16));
        return p[15:0];
    endfunction

    // Accept one operand pair, return the edge count until out_valid (100 = timeout).
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] cv, output int lat);
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        cv = c;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || c !== 16'h0000) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b c=%h, want 1 0 0 0000",
                     in_ready, out_valid, busy, c);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [15:0] va [6] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'h0003, 16'h0000};
        logic [15:0] vb [6] = '{16'h0002, 16'h0002, 16'h0000, 16'h0001, 16'h0003, 16'hABCD};
        logic [15:0] ve [6] = '{16'h0002, 16'h100B, 16'h0000, 16'h1234, 16'h0005, 16'h0000};
        logic [15:0] cv;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], cv, lat);
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL vec%0d latency: got %0d edges, want 17", i, lat);
            end
            checks++;
            if (cv !== ve[i]) begin
                errors++;
                $display("FAIL vec%0d product: got %h, want %h", i, cv, ve[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d return_idle: in_ready=%b out_valid=%b, want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] cv;
        int lat;
        out_ready = 1'b0;
        run_op(16'h0003, 16'h0003, cv, lat);
        checks++;
        if (lat !== 17 || cv !== 16'h0005) begin
            errors++;
            $display("FAIL bp_product: lat=%0d c=%h, want 17 0005", lat, cv);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || c !== 16'h0005 || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b c=%h in_ready=%b busy=%b, want 1 0005 0 0",
                         i, out_valid, c, in_ready, busy);
            end
        end
        @(negedge clk);
        a = 16'h8000; b = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_turnaround: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     in_ready, out_valid, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b, want 1", busy);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 17 || c !== 16'h100B) begin
            errors++;
            $display("FAIL bp_second_op: lat=%0d c=%h, want 17 100b", lat, c);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [15:0] cv;
        int lat;
        logic ov_seen;
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_accept: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || c !== 16'h100B) begin
            errors++;
            $display("FAIL flush_mid_calc: in_ready=%b busy=%b out_valid=%b c=%h, want 1 0 0 100b",
                     in_ready, busy, out_valid, c);
        end
        @(negedge clk);
        flush = 1'b0;
        ov_seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen = 1'b1;
        end
        checks++;
        if (ov_seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_output: out_valid seen=%b, want 0", ov_seen);
        end
        run_op(16'h8000, 16'h0002, cv, lat);
        checks++;
        if (lat !== 17 || cv !== 16'h100B) begin
            errors++;
            $display("FAIL flush_next_op: lat=%0d c=%h, want 17 100b", lat, cv);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [15:0] cv;
        int lat;
        logic ov_seen;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || c !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_calc: in_ready=%b busy=%b out_valid=%b c=%h, want 1 0 0 0000",
                     in_ready, busy, out_valid, c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        run_op(16'h1234, 16'h0001, cv, lat);
        checks++;
        if (lat !== 17 || cv !== 16'h1234) begin
            errors++;
            $display("FAIL rst_op_before_done: lat=%0d c=%h, want 17 1234", lat, cv);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || c !== 16'h0000) begin
            errors++;
            $display("FAIL rst_in_done: in_ready=%b busy=%b out_valid=%b c=%h, want 1 0 0 0000",
                     in_ready, busy, out_valid, c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        ov_seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen = 1'b1;
        end
        checks++;
        if (ov_seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale_valid: out_valid seen=%b, want 0", ov_seen);
        end
        run_op(16'h0003, 16'h0003, cv, lat);
        checks++;
        if (lat !== 17 || cv !== 16'h0005) begin
            errors++;
            $display("FAIL rst_next_op: lat=%0d c=%h, want 17 0005", lat, cv);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, exp_c;
        int accepts = 0;
        int handshakes = 0;
        int budget;
        logic done;
        for (int i = 0; i < 1500; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp_c = gf_mul(ra, rb);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d ready: in_ready=%b, want 1", i, in_ready);
            end
            a = ra; b = rb; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk);
            accepts++;
            done = 1'b0;
            budget = 0;
            while (!done && budget < 200) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (out_valid) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_ready) begin
                        handshakes++;
                        done = 1'b1;
                        checks++;
                        if (c !== exp_c) begin
                            errors++;
                            $display("FAIL rand%0d product: a=%h b=%h got %h, want %h",
                                     i, ra, rb, c, exp_c);
                        end
                    end
                end
                @(posedge clk);
                budget++;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL rand%0d timeout: no handshake in 200 cycles", i);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if (handshakes !== accepts) begin
            errors++;
            $display("FAIL rand_handshakes: got %0d, want %0d", handshakes, accepts);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
